br_resolve_ctrl: RTL
====================

Name: br_resolve_ctrl

Overview:
Sequences the branch predictor between fetch and execute. It records every predicted branch issued at fetch in an in-order in-flight queue. When each branch resolves in EX, it compares the prediction with the outcome and drives the predictor's single update port. On a misprediction it raises a one-cycle flush/redirect to the PC logic and hazard unit, and keeps saturating hit/miss statistics.

Parameters:
DEPTH, 4, in-flight queue entries (power of 2, ≥2)
IDX_W, 4, predictor index width; index = pc[IDX_W+1:2]
CNT_W, 16, statistics counter width

Ports:
CLK  in  1  clock
nRST  in  1  reset, asynchronous, active-low
fetch_push  in  1  branch fetched this cycle, prediction consumed
fetch_pc  in  32  PC of fetched branch
fetch_pred  in  1  predictor "predict" output for that branch
fetch_target  in  32  predictor target output for that branch
resolve_valid  in  1  oldest in-flight branch resolved in EX
resolve_taken  in  1  actual direction
resolve_target  in  32  actual taken target
bp_br  out  1  predictor update strobe
bp_index_update  out  IDX_W  predictor update index
bp_br_taken  out  1  predictor update direction
bp_br_target  out  32  predictor update target
mispredict  out  1  one-cycle flush pulse
redirect_pc  out  32  corrected fetch PC, valid with mispredict
full  out  1  queue full; fetch must stall branch issue
count  out  $clog2(DEPTH)+1  occupancy
proto_err  out  1  sticky: push-when-full or resolve-when-empty
hit_cnt  out  CNT_W  correct predictions, saturating
miss_cnt  out  CNT_W  mispredictions, saturating

Behaviour:
- Reset: queue empty (rd/wr pointers 0, count 0), FSM=RUN. All outputs 0, except full=0.
- Queue entry stores {pc, pred, target}. Pointers wrap modulo DEPTH. Occupancy is an explicit counter, not derived from pointers.
- FSM states: RUN, FLUSH.
  - RUN → FLUSH when a resolve is mispredicted.
  - FLUSH → RUN unconditionally after one cycle.
- Resolve (RUN, resolve_valid, count>0):
  - Pop head and compare with the outcome.
  - Mispredict when pred≠resolve_taken, or when pred=1, taken=1 and target≠resolve_target.
- Outputs are registered and appear exactly 1 cycle after the resolve cycle:
  - bp_br=1, bp_index_update=head.pc[IDX_W+1:2], bp_br_taken=resolve_taken, bp_br_target=resolve_target.
  - Every resolve updates the predictor, hit or miss.
  - On mispredict: mispredict=1 and redirect_pc = resolve_taken ? resolve_target : head.pc+4.
  - Otherwise all these outputs are 0.
- Mispredict in the resolve cycle: the queue is cleared on the next edge (pointers and count to 0). Any fetch_push in the same cycle is discarded as wrong-path.
- FLUSH cycle: fetch_push and resolve_valid are ignored, with no proto_err. The hazard unit is squashing the pipeline during this cycle.
- Simultaneous push and correct resolve: both take effect and count is unchanged. Push is allowed when full only if a resolve occurs in the same cycle.
- Push when full without a resolve: entry dropped and proto_err set. proto_err is sticky until reset.
- Resolve when empty: ignored and proto_err set.
- Counters: hit_cnt or miss_cnt increments by 1 on the output cycle and saturates at all-ones.
- Reset mid-operation: asynchronous clear of all state, including counters and proto_err. Any mispredict in progress is dropped.

Decomposition:
- Shared package (cpu_types_pkg): word_t (32-bit), the entry struct br_entry_t {word_t pc; logic pred; word_t target;}, and the FSM enum {RUN, FLUSH}.
- One natural sub-module: br_queue, a DEPTH-entry synchronous FIFO with push, pop, clear, full, count and head outputs, reusable for other in-order trackers.
- Comparison, FSM and counters stay in br_resolve_ctrl.

Test Plan:
1. Reset, then push pc=0x100 pred=0, resolve taken=0 → one cycle later: bp_br=1, index=0, taken=0; mispredict=0; hit_cnt=1.
2. Push pc=0x104 pred=0, resolve taken=1 target=0x200 → bp_br=1, index=1, taken=1, target=0x200; mispredict=1, redirect_pc=0x200; next cycle count=0, miss_cnt=1.
3. Push pc=0x108 pred=1 target=0x300, resolve taken=1 target=0x340 → mispredict=1, redirect_pc=0x340. Push pc=0x10C pred=1 target=0x400, resolve taken=0 → redirect_pc=0x110.
4. Push 3 branches, then resolve the first as mispredict with a simultaneous push → count=0 after the edge; the push during the FLUSH cycle is ignored; proto_err=0.
5. Fill DEPTH=4 → full=1. Push+resolve(hit) in the same cycle → count stays 4, proto_err=0. A lone push → proto_err=1, count=4. Resolve with count=0 → proto_err stays 1.
6. Preload hit_cnt to 0xFFFE via 2 further hits (force) → saturates at 0xFFFF. Assert nRST mid-FLUSH → all outputs 0 immediately.

Source files
------------

// File: rtl/br_resolve_ctrl_pkg.sv
// Shared types for the branch resolve controller: machine word, queue entry, FSM states.
package br_resolve_ctrl_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t pc;
    logic  pred;
    word_t target;
  } br_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // Fall-through PC of a not-taken branch.
  function automatic word_t seq_pc(input word_t pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/br_resolve_ctrl_if.sv
// Fetch/resolve inputs and predictor-update/status outputs of the resolve controller.
interface br_resolve_ctrl_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDX_W = 4,
  parameter int unsigned CNT_W = 16
);
  import br_resolve_ctrl_pkg::*;

  logic                   fetch_push;
  word_t                  fetch_pc;
  logic                   fetch_pred;
  word_t                  fetch_target;
  logic                   resolve_valid;
  logic                   resolve_taken;
  word_t                  resolve_target;
  logic                   bp_br;
  logic [IDX_W-1:0]       bp_index_update;
  logic                   bp_br_taken;
  word_t                  bp_br_target;
  logic                   mispredict;
  word_t                  redirect_pc;
  logic                   full;
  logic [$clog2(DEPTH):0] count;
  logic                   proto_err;
  logic [CNT_W-1:0]       hit_cnt;
  logic [CNT_W-1:0]       miss_cnt;

  modport master (
    output fetch_push, fetch_pc, fetch_pred, fetch_target,
           resolve_valid, resolve_taken, resolve_target,
    input  bp_br, bp_index_update, bp_br_taken, bp_br_target,
           mispredict, redirect_pc, full, count, proto_err, hit_cnt, miss_cnt
  );

  modport slave (
    input  fetch_push, fetch_pc, fetch_pred, fetch_target,
           resolve_valid, resolve_taken, resolve_target,
    output bp_br, bp_index_update, bp_br_taken, bp_br_target,
           mispredict, redirect_pc, full, count, proto_err, hit_cnt, miss_cnt
  );

endinterface

// File: rtl/br_resolve_ctrl_queue.sv
// br_queue: in-order FIFO of in-flight branch entries with explicit occupancy counter.
module br_queue
  import br_resolve_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  br_entry_t              push_data,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output br_entry_t              head
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  br_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Entry storage: written on accepted push, no reset needed.
  always_ff @(posedge CLK) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; clear empties the queue regardless of push/pop.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign full = (count == (PTR_W+1)'(DEPTH));
  assign head = mem[rd_ptr];

endmodule

// File: rtl/br_resolve_ctrl.sv
// Branch resolve controller: tracks predicted branches, updates predictor, flushes on mispredict.
module br_resolve_ctrl
  import br_resolve_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDX_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input logic               CLK,
  input logic               nRST,
  br_resolve_ctrl_if.slave  bus
);
  state_t                 state_q, state_d;
  logic                   do_resolve, miss, push_ok, err;
  logic                   q_full;
  logic [$clog2(DEPTH):0] q_count;
  br_entry_t              head, push_data;

  logic                   bp_br_q, bp_taken_q, mispredict_q, proto_err_q;
  logic [IDX_W-1:0]       bp_index_q;
  word_t                  bp_target_q, redirect_q;
  logic [CNT_W-1:0]       hit_q, miss_q;

  assign push_data = '{pc: bus.fetch_pc, pred: bus.fetch_pred, target: bus.fetch_target};

  br_queue #(.DEPTH(DEPTH)) u_queue (
    .CLK       (CLK),
    .nRST      (nRST),
    .push      (push_ok),
    .pop       (do_resolve),
    .clear     (miss),
    .push_data (push_data),
    .full      (q_full),
    .count     (q_count),
    .head      (head)
  );

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Resolve/compare, push acceptance and protocol-error detection; FLUSH ignores all requests.
  always_comb begin
    state_d    = state_q;
    do_resolve = 1'b0;
    miss       = 1'b0;
    push_ok    = 1'b0;
    err        = 1'b0;
    unique case (state_q)
      RUN: begin
        do_resolve = bus.resolve_valid && (q_count != '0);
        miss       = do_resolve &&
                     ((head.pred != bus.resolve_taken) ||
                      (head.pred && bus.resolve_taken && (head.target != bus.resolve_target)));
        // A full queue only accepts a push when the head leaves in the same cycle;
        // a mispredict squashes the push as wrong-path.
        push_ok    = bus.fetch_push && !miss && (!q_full || do_resolve);
        err        = (bus.fetch_push && q_full && !do_resolve) ||
                     (bus.resolve_valid && (q_count == '0));
        if (miss) state_d = FLUSH;
      end
      FLUSH: state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Registered predictor update, redirect, sticky error and saturating statistics.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      bp_br_q      <= 1'b0;
      bp_index_q   <= '0;
      bp_taken_q   <= 1'b0;
      bp_target_q  <= '0;
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
      proto_err_q  <= 1'b0;
      hit_q        <= '0;
      miss_q       <= '0;
    end else begin
      bp_br_q      <= 1'b0;
      bp_index_q   <= '0;
      bp_taken_q   <= 1'b0;
      bp_target_q  <= '0;
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
      proto_err_q  <= proto_err_q | err;
      if (do_resolve) begin
        bp_br_q     <= 1'b1;
        bp_index_q  <= head.pc[IDX_W+1:2];
        bp_taken_q  <= bus.resolve_taken;
        bp_target_q <= bus.resolve_target;
        if (miss) begin
          mispredict_q <= 1'b1;
          redirect_q   <= bus.resolve_taken ? bus.resolve_target : seq_pc(head.pc);
          if (miss_q != '1) miss_q <= miss_q + CNT_W'(1);
        end else begin
          if (hit_q != '1) hit_q <= hit_q + CNT_W'(1);
        end
      end
    end
  end

  assign bus.bp_br           = bp_br_q;
  assign bus.bp_index_update = bp_index_q;
  assign bus.bp_br_taken     = bp_taken_q;
  assign bus.bp_br_target    = bp_target_q;
  assign bus.mispredict      = mispredict_q;
  assign bus.redirect_pc     = redirect_q;
  assign bus.full            = q_full;
  assign bus.count           = q_count;
  assign bus.proto_err       = proto_err_q;
  assign bus.hit_cnt         = hit_q;
  assign bus.miss_cnt        = miss_q;

endmodule
